// File: rtl/plain_text_block_fifo.sv
// plain_text_block_fifo
// First-word fall-through FIFO of 128-bit plaintext blocks for the CTR core.
// Each entry carries its destination and a sequence tag, which the core adds
// to the nonce. The full flag lets the AHB slave stall instead of losing data.
module plain_text_block_fifo #(
   parameter int DEPTH = 4,
   parameter int SEQ_W = 32
) (
   input  logic                     HCLK,
   input  logic                     HRESET,
   input  logic                     write_out,
   input  logic [127:0]             plain_text,
   input  logic [31:0]              destination,
   input  logic                     out_ready,
   output logic                     out_valid,
   output logic [127:0]             out_plain_text,
   output logic [31:0]              out_destination,
   output logic [SEQ_W-1:0]         out_seq,
   output logic                     fifo_full,
   output logic                     fifo_empty,
   output logic [$clog2(DEPTH):0]   fifo_count,
   output logic                     overflow
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

   // Entry storage; it is never cleared, since count decides what is valid.
   logic [127:0]      text_mem_q [DEPTH];
   logic [31:0]       dest_mem_q [DEPTH];
   logic [SEQ_W-1:0]  seq_mem_q  [DEPTH];

   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic [SEQ_W-1:0]  next_seq_q, next_seq_d;
   logic              overflow_q, overflow_d;

   logic              full_s;
   logic              valid_s;
   logic              push_en_s;
   logic              pop_en_s;

   // Status comes only from the registered count.
   assign full_s  = (count_q == FULL_COUNT);
   assign valid_s = (count_q != CNT_W'(0));

   // A pop frees a slot in the same cycle, so a push into a full FIFO is
   // accepted when the head is leaving.
   assign pop_en_s  = out_ready & valid_s;
   assign push_en_s = write_out & (~full_s | pop_en_s);

   // Next-state logic for pointers, count, sequence tag and sticky overflow.
   always_comb begin
      rd_ptr_d   = rd_ptr_q;
      wr_ptr_d   = wr_ptr_q;
      count_d    = count_q;
      next_seq_d = next_seq_q;
      overflow_d = overflow_q;

      if (pop_en_s) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end else begin
         rd_ptr_d = rd_ptr_q;
      end

      // A dropped push does not consume a sequence number.
      if (push_en_s) begin
         wr_ptr_d   = wr_ptr_q + PTR_W'(1);
         next_seq_d = next_seq_q + SEQ_W'(1);
      end else begin
         wr_ptr_d   = wr_ptr_q;
         next_seq_d = next_seq_q;
      end

      if (write_out && !push_en_s) begin
         overflow_d = 1'b1;
      end else begin
         overflow_d = overflow_q;
      end

      case ({push_en_s, pop_en_s})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   // Control state registers; reset wins over any push or pop.
   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         count_q    <= '0;
         next_seq_q <= '0;
         overflow_q <= 1'b0;
      end else begin
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
         count_q    <= count_d;
         next_seq_q <= next_seq_d;
         overflow_q <= overflow_d;
      end
   end

   // Entry write port; pushes are gated by reset so a reset cycle stores nothing.
   always_ff @(posedge HCLK) begin
      if (push_en_s && !HRESET) begin
         text_mem_q[wr_ptr_q] <= plain_text;
         dest_mem_q[wr_ptr_q] <= destination;
         seq_mem_q[wr_ptr_q]  <= next_seq_q;
      end
   end

   // Fall-through head: entries are registers, so the head is stable while
   // the read pointer holds.
   assign out_plain_text  = text_mem_q[rd_ptr_q];
   assign out_destination = dest_mem_q[rd_ptr_q];
   assign out_seq         = seq_mem_q[rd_ptr_q];

   assign out_valid  = valid_s;
   assign fifo_full  = full_s;
   assign fifo_empty = ~valid_s;
   assign fifo_count = count_q;
   assign overflow   = overflow_q;

endmodule

// File: tb/tb_plain_text_block_fifo.sv
// Bench for plain_text_block_fifo: a queue-based reference model checked
// every cycle, plus hand-computed expectations along the directed scenarios.
module tb_plain_text_block_fifo;

   localparam int DEPTH = 4;
   localparam int SEQ_W = 32;

   logic           HCLK;
   logic           HRESET;
   logic           write_out;
   logic [127:0]   plain_text;
   logic [31:0]    destination;
   logic           out_ready;
   logic           out_valid;
   logic [127:0]   out_plain_text;
   logic [31:0]    out_destination;
   logic [SEQ_W-1:0] out_seq;
   logic           fifo_full;
   logic           fifo_empty;
   logic [2:0]     fifo_count;
   logic           overflow;

   plain_text_block_fifo #(.DEPTH(DEPTH), .SEQ_W(SEQ_W)) dut (
      .HCLK            (HCLK),
      .HRESET          (HRESET),
      .write_out       (write_out),
      .plain_text      (plain_text),
      .destination     (destination),
      .out_ready       (out_ready),
      .out_valid       (out_valid),
      .out_plain_text  (out_plain_text),
      .out_destination (out_destination),
      .out_seq         (out_seq),
      .fifo_full       (fifo_full),
      .fifo_empty      (fifo_empty),
      .fifo_count      (fifo_count),
      .overflow        (overflow)
   );

   initial HCLK = 1'b0;
   always #5 HCLK = ~HCLK;

   typedef struct packed {
      logic [127:0] t;
      logic [31:0]  d;
      logic [31:0]  s;
   } ent_t;

   ent_t        mq[$];
   logic [31:0] m_next_seq;
   logic        m_overflow;
   logic        model_live;

   int checks;
   int failures;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: acts on the inputs that were present at the last edge.
   task automatic model_update();
      bit   pop;
      bit   push;
      ent_t e;
      if (HRESET) begin
         mq.delete();
         m_next_seq = 32'd0;
         m_overflow = 1'b0;
      end else begin
         pop  = out_ready && (mq.size() > 0);
         push = write_out && ((mq.size() < DEPTH) || pop);
         if (write_out && !push) m_overflow = 1'b1;
         if (pop) void'(mq.pop_front());
         if (push) begin
            e.t = plain_text;
            e.d = destination;
            e.s = m_next_seq;
            mq.push_back(e);
            m_next_seq = m_next_seq + 32'd1;
         end
      end
   endtask

   // One clock: drive inputs, let the edge happen, then advance the model.
   task automatic step(input logic w, input logic [127:0] pt, input logic [31:0] d,
                       input logic r, input logic rst);
      write_out   = w;
      plain_text  = pt;
      destination = d;
      out_ready   = r;
      HRESET      = rst;
      @(posedge HCLK);
      #1;
      model_update();
      model_live = 1'b1;
   endtask

   // Per-cycle comparison of the DUT against the model, away from the edge.
   always @(negedge HCLK) begin
      if (model_live) begin
         chk("out_valid",  out_valid,  (mq.size() > 0));
         chk("fifo_empty", fifo_empty, (mq.size() == 0));
         chk("fifo_full",  fifo_full,  (mq.size() == DEPTH));
         chk("fifo_count", fifo_count, mq.size());
         chk("overflow",   overflow,   m_overflow);
         if (mq.size() > 0) begin
            chk("head_text", out_plain_text,  mq[0].t);
            chk("head_dest", out_destination, mq[0].d);
            chk("head_seq",  out_seq,         mq[0].s);
         end
      end
   end

   initial begin
      checks     = 0;
      failures   = 0;
      model_live = 1'b0;
      m_next_seq = 32'd0;
      m_overflow = 1'b0;
      write_out  = 1'b0;
      plain_text = 128'd0;
      destination = 32'd0;
      out_ready  = 1'b0;
      HRESET     = 1'b1;

      // Reset then idle.
      step(1'b0, 128'd0, 32'd0, 1'b0, 1'b1);
      for (int i = 0; i < 3; i++) step(1'b0, 128'd0, 32'd0, 1'b0, 1'b0);
      chk("idle_valid", out_valid, 1'b0);
      chk("idle_empty", fifo_empty, 1'b1);
      chk("idle_count", fifo_count, 3'd0);
      chk("idle_ovf",   overflow, 1'b0);

      // Single push, visible next cycle.
      step(1'b1, 128'h1, 32'h10101010, 1'b0, 1'b0);
      chk("one_valid", out_valid, 1'b1);
      chk("one_text",  out_plain_text, 128'h1);
      chk("one_dest",  out_destination, 32'h10101010);
      chk("one_seq",   out_seq, 32'd0);
      chk("one_count", fifo_count, 3'd1);
      step(1'b0, 128'd0, 32'd0, 1'b1, 1'b0);
      chk("one_popped_empty", fifo_empty, 1'b1);

      // Fill A..D, drop E, drain in order.
      step(1'b0, 128'd0, 32'd0, 1'b0, 1'b1);
      for (int i = 0; i < 4; i++) step(1'b1, 128'(10 + i), 32'(32'hD000 + i), 1'b0, 1'b0);
      step(1'b1, 128'hE, 32'hD00E, 1'b0, 1'b0);
      chk("fill_full",  fifo_full, 1'b1);
      chk("fill_ovf",   overflow, 1'b1);
      chk("fill_count", fifo_count, 3'd4);
      for (int i = 0; i < 4; i++) begin
         chk("drain_text", out_plain_text, 128'(10 + i));
         chk("drain_seq",  out_seq, 32'(i));
         step(1'b0, 128'd0, 32'd0, 1'b1, 1'b0);
      end
      chk("drain_empty", fifo_empty, 1'b1);
      chk("ovf_sticky",  overflow, 1'b1);

      // Full with simultaneous push and pop; F takes seq 4.
      step(1'b0, 128'd0, 32'd0, 1'b0, 1'b1);
      for (int i = 0; i < 4; i++) step(1'b1, 128'(10 + i), 32'(32'hD000 + i), 1'b0, 1'b0);
      step(1'b1, 128'hE, 32'hD00E, 1'b0, 1'b0);
      step(1'b1, 128'hF, 32'hD00F, 1'b1, 1'b0);
      chk("pp_count", fifo_count, 3'd4);
      chk("pp_full",  fifo_full, 1'b1);
      chk("pp_head",  out_plain_text, 128'hB);
      for (int i = 0; i < 3; i++) step(1'b0, 128'd0, 32'd0, 1'b1, 1'b0);
      chk("f_text", out_plain_text, 128'hF);
      chk("f_seq",  out_seq, 32'd4);
      step(1'b0, 128'd0, 32'd0, 1'b1, 1'b0);
      chk("f_empty", fifo_empty, 1'b1);

      // Reset mid-stream with a push pending.
      step(1'b1, 128'h21, 32'hA1, 1'b0, 1'b0);
      step(1'b1, 128'h22, 32'hA2, 1'b0, 1'b0);
      chk("pre_rst_count", fifo_count, 3'd2);
      step(1'b1, 128'h23, 32'hA3, 1'b0, 1'b1);
      chk("rst_empty", fifo_empty, 1'b1);
      chk("rst_ovf",   overflow, 1'b0);
      chk("rst_count", fifo_count, 3'd0);
      step(1'b1, 128'h24, 32'hA4, 1'b0, 1'b0);
      chk("post_rst_text", out_plain_text, 128'h24);
      chk("post_rst_seq",  out_seq, 32'd0);

      // Streaming: ten blocks through an otherwise empty FIFO.
      step(1'b0, 128'd0, 32'd0, 1'b0, 1'b1);
      for (int k = 0; k < 10; k++) begin
         step(1'b1, 128'(32'h5000 + k), 32'(32'hB000 + k), 1'b1, 1'b0);
         chk("stream_count_le1", (fifo_count <= 3'd1), 1'b1);
         chk("stream_seq",  out_seq, 32'(k));
         chk("stream_text", out_plain_text, 128'(32'h5000 + k));
      end
      step(1'b0, 128'd0, 32'd0, 1'b1, 1'b0);
      chk("stream_end_empty", fifo_empty, 1'b1);
      step(1'b0, 128'd0, 32'd0, 1'b0, 1'b0);

      model_live = 1'b0;
      @(negedge HCLK);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/plain_text_block_fifo.md
Name: plain_text_block_fifo

Overview:
- Buffers 128-bit plaintext blocks produced by the AHB-Lite slave interface (write_out strobe with plain_text/destination) and hands them to the CTR-mode encryption core.
- Tags each block with a monotonically increasing sequence number, which the core adds to the nonce to form the counter block.
- Drives fifo_full back to the slave so the slave stalls the bus (HREADYOUT low) instead of losing data.
- First-word fall-through: the head entry is visible on the outputs whenever out_valid is high.

Parameters:
- DEPTH, 4, number of block entries; power of two, ≥2.
- SEQ_W, 32, width of the sequence tag; wraps modulo 2^SEQ_W.

Ports:
- HCLK  input  1  system clock; all state updates on rising edge.
- HRESET  input  1  synchronous, active-high reset.
- write_out  input  1  push strobe from slave; one block per high cycle.
- plain_text  input  128  block to push; sampled when write_out=1.
- destination  input  32  destination address to push with block; sampled when write_out=1.
- out_ready  input  1  consumer accepts head entry this cycle.
- out_valid  output  1  head entry valid (FIFO not empty).
- out_plain_text  output  128  head entry plaintext.
- out_destination  output  32  head entry destination.
- out_seq  output  SEQ_W  head entry sequence tag.
- fifo_full  output  1  count == DEPTH.
- fifo_empty  output  1  count == 0.
- fifo_count  output  $clog2(DEPTH)+1  number of stored entries.
- overflow  output  1  sticky; set when a push is dropped.

Behaviour:
- Reset (HRESET=1 at a rising edge):
  - Read pointer, write pointer, count, next_seq and overflow all go to 0.
  - out_valid=0, fifo_empty=1, fifo_full=0, fifo_count=0.
  - Entry storage is not cleared. Head data outputs are don't-care while out_valid=0.
  - Reset overrides any push or pop in the same cycle. Reset mid-stream discards all contents.
- Storage: DEPTH entries of {plain_text, destination, seq}. Pointers are $clog2(DEPTH) bits and wrap DEPTH-1 → 0.
- Push: push_en = write_out & (~fifo_full | pop_en).
  - Writes {plain_text, destination, next_seq} at the write pointer.
  - Write pointer increments; next_seq increments, wrapping 2^SEQ_W-1 → 0.
- Pop: pop_en = out_ready & out_valid. Read pointer increments. out_ready while empty is ignored.
- Count update: +1 on push only, -1 on pop only, unchanged when both or neither occur.
- Full with simultaneous push and pop: both happen; count stays DEPTH and fifo_full stays 1.
- Empty with push: the entry becomes visible the next cycle (out_valid=1). No same-cycle bypass.
- Dropped push: write_out=1 while full and no pop. The entry is discarded, next_seq is unchanged, and overflow is set to 1. overflow clears only on reset.
- Status outputs: fifo_full, fifo_empty, fifo_count and out_valid are derived from the registered count only (no combinational path from inputs).
- Latency: push to out_valid is 1 cycle. Pop advances the head on the next cycle.
- Output stability: head outputs are stable while out_valid=1 and out_ready=0.

Test Plan:
- Reset then idle, 3 cycles → out_valid=0, fifo_empty=1, fifo_count=0, overflow=0.
- Push plain_text=128'h1 / destination=32'h10101010 with out_ready=0 → next cycle: out_valid=1, out_plain_text=128'h1, out_destination=32'h10101010, out_seq=0, fifo_count=1.
- Push 4 blocks 128'hA..128'hD (DEPTH=4), then a 5th push of 128'hE → fifo_full=1, overflow=1, fifo_count=4. Popping 4 times yields A,B,C,D with seq 0,1,2,3, then fifo_empty=1.
- When full, push 128'hF and assert out_ready in the same cycle → count stays 4, head advances. The 128'hF entry, popped last, carries seq 4, because the dropped 128'hE did not consume a sequence number.
- Fill to 2 entries, assert HRESET for one cycle with write_out=1 → fifo_empty=1, overflow=0. The next push carries seq 0.
- Continuous push/pop for 10 blocks starting from empty → pointers wrap correctly, out_seq runs 0..9 in order, and fifo_count never exceeds 1.
